// File: rtl/nibble_packer_if.sv
// Handshake bundle between the nibble front end, the packer and the word consumer.
// The slave modport is the packer's view; the master modport is the surrounding logic's.
interface nibble_packer_if #(
  parameter int NIBBLES = 4
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  logic          in_valid;
  logic [3:0]    in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_last;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/nibble_packer.sv
// Packs NIBBLES consecutive 4-bit nibbles into one word behind a one-entry output register,
// with a sticky flush that emits a zero-padded partial word tagged by its nibble count.
module nibble_packer #(
  parameter int NIBBLES   = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  nibble_packer_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

  logic [W-1:0]  acc, acc_next;
  logic [CW-1:0] cnt, cnt_next, pos;
  logic          flush_pend;
  logic          out_valid_q, out_last_q;
  logic [W-1:0]  out_data_q;
  logic [CW-1:0] out_count_q;

  logic slot_free, accept, complete, flush_any, emit_partial, load;

  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    slot_free    = !out_valid_q || bus.out_ready;
    bus.in_ready = reset && ((cnt != LAST_IDX) || slot_free);
    accept       = bus.in_valid && bus.in_ready;
    pos          = LSB_FIRST ? cnt : LAST_IDX - cnt;
    acc_next     = acc;
    if (accept) acc_next[4*pos +: 4] = bus.in_data;
    cnt_next     = cnt + CW'(accept);
    // Only the word-completing nibble can be back-pressured, so complete implies slot_free.
    complete     = accept && (cnt == LAST_IDX);
    flush_any    = flush_pend || bus.flush;
    emit_partial = !complete && flush_any && (cnt_next != '0) && slot_free;
    load         = complete || emit_partial;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc         <= '0;
      cnt         <= '0;
      flush_pend  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_next;
      out_count_q <= cnt_next;
      out_last_q  <= complete ? flush_any : 1'b1;
      acc         <= '0;
      cnt         <= '0;
      flush_pend  <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      acc        <= acc_next;
      cnt        <= cnt_next;
      // A flush with nothing to emit is dropped rather than left pending.
      flush_pend <= flush_any && (cnt_next != '0);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: an LSB-first and an MSB-first instance see identical stimulus.
// Inputs change 1ns after posedge; registered outputs are sampled at that same point.
module tb_nibble_packer;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nibble_packer_if #(.NIBBLES(4)) bus_a ();
  nibble_packer_if #(.NIBBLES(4)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.flush     = bus_a.flush;
  assign bus_b.out_ready = bus_a.out_ready;

  nibble_packer #(.NIBBLES(4), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .reset(reset), .bus(bus_a.slave));
  nibble_packer #(.NIBBLES(4), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .reset(reset), .bus(bus_b.slave));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [3:0] d);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'h7; bus_a.flush = 1'b0; bus_a.out_ready = 1'b1;
    #1;
    cyc(); cyc();
    if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus_a.in_ready); end checks++;
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus_a.out_valid); end checks++;
    if (bus_a.out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0000", bus_a.out_data); end checks++;
    if (bus_a.out_count !== 3'd0) begin errors++; $display("FAIL rst_out_count: got %0d want 0", bus_a.out_count); end checks++;
    if (bus_a.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", bus_a.out_last); end checks++;
    bus_a.in_valid = 1'b0;
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_full_word();
    feed(4'h1); feed(4'h2); feed(4'h3); feed(4'h4);
    bus_a.in_valid = 1'b0;
    if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL word_valid: got %b want 1", bus_a.out_valid); end checks++;
    if (bus_a.out_data !== 16'h4321) begin errors++; $display("FAIL word_lsb_data: got %h want 4321", bus_a.out_data); end checks++;
    if (bus_b.out_data !== 16'h1234) begin errors++; $display("FAIL word_msb_data: got %h want 1234", bus_b.out_data); end checks++;
    if (bus_a.out_count !== 3'd4) begin errors++; $display("FAIL word_count: got %0d want 4", bus_a.out_count); end checks++;
    if (bus_a.out_last !== 1'b0) begin errors++; $display("FAIL word_last: got %b want 0", bus_a.out_last); end checks++;
    cyc();
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL word_drain: got %b want 0", bus_a.out_valid); end checks++;
  endtask

  task automatic test_flush_partial();
    feed(4'hA); feed(4'hB);
    bus_a.in_valid = 1'b0;
    bus_a.flush = 1'b1;
    cyc();
    bus_a.flush = 1'b0;
    if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL part_valid: got %b want 1", bus_a.out_valid); end checks++;
    if (bus_a.out_data !== 16'h00BA) begin errors++; $display("FAIL part_lsb_data: got %h want 00ba", bus_a.out_data); end checks++;
    if (bus_b.out_data !== 16'hAB00) begin errors++; $display("FAIL part_msb_data: got %h want ab00", bus_b.out_data); end checks++;
    if (bus_a.out_count !== 3'd2) begin errors++; $display("FAIL part_count: got %0d want 2", bus_a.out_count); end checks++;
    if (bus_a.out_last !== 1'b1) begin errors++; $display("FAIL part_last: got %b want 1", bus_a.out_last); end checks++;
    cyc();
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL part_drain: got %b want 0", bus_a.out_valid); end checks++;
  endtask

  task automatic test_back_pressure();
    bus_a.out_ready = 1'b0;
    feed(4'h1); feed(4'h2); feed(4'h3); feed(4'h4);
    if (bus_a.out_data !== 16'h4321) begin errors++; $display("FAIL bp_first_data: got %h want 4321", bus_a.out_data); end checks++;
    feed(4'h5); feed(4'h6); feed(4'h7);
    bus_a.in_data = 4'h8;
    #1;
    if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", bus_a.in_ready); end checks++;
    cyc();
    if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold: got %b want 0", bus_a.in_ready); end checks++;
    if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %b want 1", bus_a.out_valid); end checks++;
    if (bus_a.out_data !== 16'h4321) begin errors++; $display("FAIL bp_data_hold: got %h want 4321", bus_a.out_data); end checks++;
    bus_a.out_ready = 1'b1;
    #1;
    if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_rise: got %b want 1", bus_a.in_ready); end checks++;
    cyc();
    bus_a.in_valid = 1'b0;
    if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got %b want 1", bus_a.out_valid); end checks++;
    if (bus_a.out_data !== 16'h8765) begin errors++; $display("FAIL bp_second_lsb: got %h want 8765", bus_a.out_data); end checks++;
    if (bus_b.out_data !== 16'h5678) begin errors++; $display("FAIL bp_second_msb: got %h want 5678", bus_b.out_data); end checks++;
    if (bus_a.out_last !== 1'b0) begin errors++; $display("FAIL bp_second_last: got %b want 0", bus_a.out_last); end checks++;
    cyc();
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus_a.out_valid); end checks++;
  endtask

  task automatic test_flush_on_last();
    feed(4'h1); feed(4'h2); feed(4'h3);
    bus_a.flush = 1'b1;
    feed(4'h4);
    bus_a.flush = 1'b0;
    bus_a.in_valid = 1'b0;
    if (bus_a.out_data !== 16'h4321) begin errors++; $display("FAIL fl4_data: got %h want 4321", bus_a.out_data); end checks++;
    if (bus_a.out_count !== 3'd4) begin errors++; $display("FAIL fl4_count: got %0d want 4", bus_a.out_count); end checks++;
    if (bus_a.out_last !== 1'b1) begin errors++; $display("FAIL fl4_last: got %b want 1", bus_a.out_last); end checks++;
    bus_a.flush = 1'b1;
    cyc();
    bus_a.flush = 1'b0;
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL fl_empty_a: got %b want 0", bus_a.out_valid); end checks++;
    cyc();
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL fl_empty_b: got %b want 0", bus_a.out_valid); end checks++;
  endtask

  task automatic test_flush_blocked();
    bus_a.out_ready = 1'b0;
    feed(4'h1); feed(4'h2); feed(4'h3); feed(4'h4);
    bus_a.flush = 1'b1;
    feed(4'h5);
    bus_a.flush = 1'b0;
    feed(4'h6);
    bus_a.in_valid = 1'b0;
    if (bus_a.out_data !== 16'h4321) begin errors++; $display("FAIL flb_hold: got %h want 4321", bus_a.out_data); end checks++;
    if (bus_a.out_last !== 1'b0) begin errors++; $display("FAIL flb_hold_last: got %b want 0", bus_a.out_last); end checks++;
    bus_a.out_ready = 1'b1;
    cyc();
    if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL flb_valid: got %b want 1", bus_a.out_valid); end checks++;
    if (bus_a.out_data !== 16'h0065) begin errors++; $display("FAIL flb_lsb_data: got %h want 0065", bus_a.out_data); end checks++;
    if (bus_b.out_data !== 16'h5600) begin errors++; $display("FAIL flb_msb_data: got %h want 5600", bus_b.out_data); end checks++;
    if (bus_a.out_count !== 3'd2) begin errors++; $display("FAIL flb_count: got %0d want 2", bus_a.out_count); end checks++;
    if (bus_a.out_last !== 1'b1) begin errors++; $display("FAIL flb_last: got %b want 1", bus_a.out_last); end checks++;
    cyc();
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL flb_drain: got %b want 0", bus_a.out_valid); end checks++;
  endtask

  task automatic test_reset_mid();
    bus_a.out_ready = 1'b0;
    feed(4'h1); feed(4'h2); feed(4'h3); feed(4'h4);
    feed(4'h5); feed(4'h6);
    bus_a.in_valid = 1'b0;
    reset = 1'b0;
    cyc();
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus_a.out_valid); end checks++;
    if (bus_a.out_data !== 16'h0) begin errors++; $display("FAIL mid_data: got %h want 0000", bus_a.out_data); end checks++;
    if (bus_a.out_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", bus_a.out_count); end checks++;
    if (bus_a.out_last !== 1'b0) begin errors++; $display("FAIL mid_last: got %b want 0", bus_a.out_last); end checks++;
    reset = 1'b1;
    bus_a.out_ready = 1'b1;
    feed(4'h1); feed(4'h2); feed(4'h3); feed(4'h4);
    bus_a.in_valid = 1'b0;
    if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL mid_after_valid: got %b want 1", bus_a.out_valid); end checks++;
    if (bus_a.out_data !== 16'h4321) begin errors++; $display("FAIL mid_after_data: got %h want 4321", bus_a.out_data); end checks++;
    if (bus_a.out_count !== 3'd4) begin errors++; $display("FAIL mid_after_count: got %0d want 4", bus_a.out_count); end checks++;
    cyc();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_back_pressure();
    test_flush_on_last();
    test_flush_blocked();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
